// File: rtl/port_bus_arbiter.sv
// Two-master arbiter onto 16 byte-wide I/O ports: round-robin grant, a 3-state
// access FSM, per-port input synchronizers with change flags, registered outputs.

module port_bus_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_in,
    input  logic       set_ok,
    input  logic       wr_en,
    input  logic [7:0] wdata,
    input  logic       rd_clr,
    output logic [7:0] sync_data,
    output logic [7:0] port_out,
    output logic       chg
);
    logic [7:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta      <= 8'h00;
            sync_data <= 8'h00;
            port_out  <= 8'h00;
            chg       <= 1'b0;
        end else begin
            meta      <= port_in;
            sync_data <= meta;
            if (wr_en)
                port_out <= wdata;
            // a change landing on the read edge must not be lost, so set beats clear
            if (set_ok && (meta != sync_data))
                chg <= 1'b1;
            else if (rd_clr)
                chg <= 1'b0;
        end
    end
endmodule

module port_bus_arbiter (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m1_req,
    input  logic             m0_we,
    input  logic             m1_we,
    input  logic [3:0]       m0_addr,
    input  logic [3:0]       m1_addr,
    input  logic [7:0]       m0_wdata,
    input  logic [7:0]       m1_wdata,
    output logic             m0_ack,
    output logic             m1_ack,
    output logic [7:0]       rdata,
    output logic             busy,
    input  logic [15:0][7:0] port_in_data,
    output logic [15:0][7:0] port_out_data,
    output logic [15:0]      chg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

    state_t           state, state_next;
    logic [1:0]       req, pend, eff;
    logic             win, gnt, last_grant, grant_fire;
    logic             t_we;
    logic [3:0]       t_addr;
    logic [7:0]       t_wdata;
    logic [1:0]       sync_vld;
    logic [15:0][7:0] sync_data;
    logic [15:0]      wr_en, rd_clr;

    assign req        = {m1_req, m0_req};
    assign eff        = req | pend;
    assign win        = (eff == 2'b11) ? ~last_grant : eff[1];
    assign grant_fire = (state == IDLE) && (eff != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (eff != 2'b00) state_next = ACCESS;
            end
            ACCESS: state_next = ACK;
            ACK: begin
                state_next = IDLE;
                m0_ack     = ~gnt;
                m1_ack     = gnt;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            pend       <= 2'b00;
            t_we       <= 1'b0;
            t_addr     <= 4'h0;
            t_wdata    <= 8'h00;
            rdata      <= 8'h00;
            sync_vld   <= 2'b00;
        end else begin
            // compare only once the second stage holds a value sampled after reset
            sync_vld <= {sync_vld[0], 1'b1};
            if (grant_fire) begin
                gnt        <= win;
                last_grant <= win;
                pend       <= 2'b00;
                t_we       <= win ? m1_we    : m0_we;
                t_addr     <= win ? m1_addr  : m0_addr;
                t_wdata    <= win ? m1_wdata : m0_wdata;
            end else if (state != IDLE) begin
                // the granted master still holds req; only the other one is queued
                pend <= pend | (req & (gnt ? 2'b01 : 2'b10));
            end
            if ((state == ACCESS) && !t_we)
                rdata <= sync_data[t_addr];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lane
        assign wr_en[i]  = (state == ACCESS) &&  t_we && (t_addr == 4'(i));
        assign rd_clr[i] = (state == ACCESS) && !t_we && (t_addr == 4'(i));

        port_bus_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .port_in   (port_in_data[i]),
            .set_ok    (sync_vld[1]),
            .wr_en     (wr_en[i]),
            .wdata     (t_wdata),
            .rd_clr    (rd_clr[i]),
            .sync_data (sync_data[i]),
            .port_out  (port_out_data[i]),
            .chg       (chg[i])
        );
    end
endmodule

// File: tb/tb_port_bus_arbiter.sv
// Directed bench for port_bus_arbiter: transaction-level reference model compared
// every cycle, plus literal expectations for the key scenarios.

module tb_port_bus_arbiter;
    logic             clk = 1'b0;
    logic             reset;
    logic             m0_req, m1_req, m0_we, m1_we;
    logic [3:0]       m0_addr, m1_addr;
    logic [7:0]       m0_wdata, m1_wdata;
    logic             m0_ack, m1_ack, busy;
    logic [7:0]       rdata;
    logic [15:0][7:0] port_in_data;
    logic [15:0][7:0] port_out_data;
    logic [15:0]      chg;

    int errors = 0;
    int checks = 0;
    int n_ack0 = 0;
    int n_ack1 = 0;

    port_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata), .busy(busy),
        .port_in_data(port_in_data), .port_out_data(port_out_data), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one transaction occupies three clock edges (grant, access, release).
    logic [15:0][7:0] e_out, e_s1, e_s2;
    logic [15:0]      e_chg;
    logic [7:0]       e_rdata, e_wdata;
    logic [3:0]       e_addr;
    bit               e_txn, e_who, e_we, e_last;
    bit   [1:0]       e_pend;
    int               e_t0, e_edges, e_prime;

    always @(posedge clk or negedge reset) begin
        logic [15:0] setm, clrm;
        bit   [1:0]  rq, eff;
        if (!reset) begin
            e_out = '0; e_s1 = '0; e_s2 = '0; e_chg = '0; e_rdata = '0;
            e_wdata = '0; e_addr = '0; e_txn = 0; e_who = 0; e_we = 0;
            e_last = 1; e_pend = 0; e_t0 = 0; e_edges = 0; e_prime = 0;
        end else begin
            setm = '0;
            clrm = '0;
            if (e_prime >= 2)
                for (int i = 0; i < 16; i++) setm[i] = (e_s1[i] != e_s2[i]);
            if (e_txn && e_edges == e_t0 + 1) begin
                if (e_we) e_out[e_addr] = e_wdata;
                else begin
                    e_rdata = e_s2[e_addr];
                    clrm[e_addr] = 1'b1;
                end
            end
            e_chg = setm | (e_chg & ~clrm);
            e_s2 = e_s1;
            e_s1 = port_in_data;
            if (e_prime < 2) e_prime++;
            rq = {m1_req, m0_req};
            if (e_txn) begin
                if (e_who) e_pend[0] = e_pend[0] | rq[0];
                else       e_pend[1] = e_pend[1] | rq[1];
                if (e_edges == e_t0 + 2) e_txn = 0;
            end else begin
                eff = rq | e_pend;
                if (eff != 2'b00) begin
                    e_who   = (eff == 2'b11) ? !e_last : eff[1];
                    e_we    = e_who ? m1_we    : m0_we;
                    e_addr  = e_who ? m1_addr  : m0_addr;
                    e_wdata = e_who ? m1_wdata : m0_wdata;
                    e_last  = e_who;
                    e_pend  = 0;
                    e_txn   = 1;
                    e_t0    = e_edges;
                end
            end
            e_edges++;
        end
    end

    always @(posedge clk) begin
        bit in_ack;
        #2;
        in_ack = e_txn && (e_edges == e_t0 + 2);
        chk("busy", busy, e_txn);
        chk("m0_ack", m0_ack, in_ack && !e_who);
        chk("m1_ack", m1_ack, in_ack && e_who);
        chk("rdata", rdata, e_rdata);
        chk("port_out_data", port_out_data, e_out);
        chk("chg", chg, e_chg);
        if (m0_ack) n_ack0++;
        if (m1_ack) n_ack1++;
    end

    task automatic drive(input bit m, input bit rq, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (m) begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    // Called on a negedge; returns on the negedge inside the ACK cycle, req dropped.
    task automatic do_txn(input bit m, input bit we, input logic [3:0] a, input logic [7:0] d, output int lat);
        lat = -1;
        drive(m, 1, we, a, d);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) drive(m, 1, we, ~a, ~d);
            if (m ? m1_ack : m0_ack) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 0, 1);
        drive(m, 0, 0, 4'h0, 8'h00);
    endtask

    initial begin
        logic [15:0][7:0] exp_po;
        int lat, n, t0a, t1a, a0, a1;
        int when [8];
        bit [3:0] who;
        reset = 1'b0;
        port_in_data = '0;
        drive(0, 0, 0, 4'h0, 8'h00);
        drive(1, 0, 0, 4'h0, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_out", port_out_data, '0);
        chk("rst_chg", chg, 16'h0000);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // m0 write port 3
        a1 = n_ack1;
        do_txn(0, 1, 4'd3, 8'hA5, lat);
        chk("wr_latency", lat, 2);
        exp_po = '0;
        exp_po[3] = 8'hA5;
        chk("wr_port3", port_out_data, exp_po);
        chk("wr_no_m1_ack", n_ack1 - a1, 0);
        @(negedge clk);

        // input change on port 7 then m1 read
        port_in_data[7] = 8'h3C;
        @(negedge clk);
        chk("chg7_early", chg[7], 0);
        @(negedge clk);
        chk("chg7_set", chg[7], 1);
        do_txn(1, 0, 4'd7, 8'h00, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data7", rdata, 8'h3C);
        chk("chg7_clr", chg[7], 0);
        @(negedge clk);

        // port 2 changes on the very edge it is read
        port_in_data[2] = 8'h55;
        do_txn(0, 0, 4'd2, 8'h00, lat);
        chk("rd_data2_old", rdata, 8'h00);
        chk("chg2_set_wins", chg[2], 1);
        repeat (2) @(negedge clk);

        // both masters request continuously out of reset
        reset = 1'b0;
        drive(0, 1, 1, 4'd0, 8'h11);
        drive(1, 1, 1, 4'd1, 8'h22);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        who = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((m0_ack || m1_ack) && n < 8) begin
                if (n < 4) who[n] = m1_ack;
                when[n] = k;
                n++;
            end
        end
        chk("rr_count", n, 4);
        chk("rr_order", who, 4'b1010);
        chk("rr_spacing", {when[1] - when[0], when[2] - when[1], when[3] - when[2]}, {32'd3, 32'd3, 32'd3});
        drive(0, 0, 0, 4'h0, 8'h00);
        drive(1, 0, 0, 4'h0, 8'h00);
        repeat (6) @(negedge clk);
        chk("no_chg_after_reset", chg, 16'h0000);

        // reset in the middle of a write
        a0 = n_ack0;
        drive(0, 1, 1, 4'd5, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ack", m0_ack, 0);
        chk("abort_out", port_out_data, '0);
        drive(0, 0, 0, 4'h0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_ack", n_ack0 - a0, 0);
        chk("abort_out_after", port_out_data[5], 8'h00);

        // m1 queues behind m0
        t0a = -1;
        t1a = -1;
        drive(0, 1, 1, 4'd9, 8'h5A);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) drive(1, 1, 0, 4'd2, 8'h00);
            if (m0_ack && t0a < 0) begin t0a = k; drive(0, 0, 0, 4'h0, 8'h00); end
            if (m1_ack && t1a < 0) begin t1a = k; drive(1, 0, 0, 4'h0, 8'h00); end
        end
        chk("pend_m0_ack", t0a, 2);
        chk("pend_m1_gap", t1a - t0a, 3);
        chk("pend_port9", port_out_data[9], 8'h5A);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/port_bus_arbiter.md
PORT_BUS_ARBITER -- requirements
Module: port_bus_arbiter

Interface
REQ-001 The block SHALL have no parameters: 16 ports, 8-bit data, 4-bit port address, all fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, release is synchronous to clk.
REQ-004 m0_req, m1_req  input  1 each  access request from master 0 (CPU) and master 1 (debug/DMA).
REQ-005 m0_we, m1_we  input  1 each  1 = write output port, 0 = read input port.
REQ-006 m0_addr, m1_addr  input  4 each  port index 0..15.
REQ-007 m0_wdata, m1_wdata  input  8 each  write data.
REQ-008 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-009 rdata  output  8  read data; valid only while an ack is high.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 port_in_data  input  16 x 8  external input ports, asynchronous to clk.
REQ-012 port_out_data  output  16 x 8  registered output ports.
REQ-013 chg  output  16  per-port input-changed flags.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS, ACK; transitions IDLE->ACCESS when any req is high, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-015 In IDLE, a single requesting master SHALL be granted; when both request, the master not granted last SHALL win (round-robin via a last_grant register).
REQ-016 On grant, the winner's we, addr, wdata SHALL be latched; later changes to master inputs SHALL not affect the transaction.
REQ-017 In ACCESS, a write SHALL update port_out_data[addr] at the ACCESS->ACK edge; other ports SHALL hold.
REQ-018 In ACCESS, a read SHALL capture the synchronized value of port_in_data[addr] into rdata.
REQ-019 In ACK, only the granted master's ack SHALL be high, for exactly one cycle; latency req-sampled to ack high = 2 cycles after the IDLE sampling edge.
REQ-020 Masters SHALL drop req at the edge ending ACK; a req still high in the following IDLE SHALL be treated as a new transaction.
REQ-021 A master's req raised during ACCESS/ACK SHALL be held pending and arbitrated in the next IDLE.
REQ-022 Each port_in_data byte SHALL pass through a 2-flop synchronizer; reads SHALL return the second-stage value (input-to-visible latency 2 cycles).
REQ-023 chg[i] SHALL set when the synchronized byte i differs from its previous-cycle value, and clear when port i is read (ACCESS, we=0).
REQ-024 If set and clear of chg[i] coincide in the same cycle, set SHALL win.
REQ-025 rdata SHALL hold its last value outside ACK; writes SHALL leave rdata unchanged.

Reset
REQ-026 While reset is low: state=IDLE, m0_ack=m1_ack=0, busy=0, rdata=8'h00, all port_out_data=8'h00, chg=16'h0000, synchronizer flops=8'h00, last_grant=master 1 (so master 0 wins the first tie).
REQ-027 Reset asserted mid-transaction SHALL abort it: no ack, no port_out_data update, outputs at reset values within the same cycle.
REQ-028 Changes on port_in_data during reset SHALL not set chg after release until they differ from the synchronized value captured post-reset.

Verification
REQ-029 Reset, then m0 write addr=3 wdata=8'hA5 -> m0_ack high 2 cycles after grant, port_out_data[3]=8'hA5, all other ports 8'h00, m1_ack never high.
REQ-030 port_in_data[7]=8'h3C held stable, m1 read addr=7 -> m1_ack one cycle with rdata=8'h3C; chg[7] set 2 cycles after input change and cleared by the read.
REQ-031 m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1; each ack one cycle, 3 cycles per transaction.
REQ-032 port_in_data[2] changes in the same cycle port 2 is read -> chg[2] remains 1 after the read.
REQ-033 Reset pulled low during ACCESS of m0 write addr=5 wdata=8'hFF -> port_out_data[5]=8'h00, no ack, busy=0 immediately.
REQ-034 m1 raises req during m0's ACCESS -> m1 granted in the next IDLE, m1_ack 3 cycles after m0_ack.
